tilelink_sram_slave: RTL and testbench

- TileLink Uncached Heavyweight (TL-UH) responder that terminates one slave port of tilelink_xbr, i.e. one d_tluh_o/d_tluh_i pair.
- Backs the port with a DEPTH x 32-bit synchronous word memory.
- Serves Get, PutFullData, PutPartialData, ArithmeticData, LogicalData and Intent on the A channel, and returns exactly one single-beat D response per request.
- Handles one outstanding request at a time; no pipelining.

---
 rtl/tilelink_sram_slave.sv | 265 ++++++++++++++++++++++++++
 tb/tb_tilelink_sram_slave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tilelink_sram_slave.sv
// TL-UH responder backed by a DEPTH x 32-bit synchronous word memory, one request in flight.
// Latency A-accept to d_valid: 1 edge (Put/Intent/denied), 2 (Get), 3 (Arithmetic/Logical).
// Backpressure: a_ready only in IDLE; D fields are held stable in RESP until d_ready.
package tluh;
  typedef enum logic [2:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    ARITHMETIC_DATA  = 3'd2,
    LOGICAL_DATA     = 3'd3,
    GET              = 3'd4,
    INTENT           = 3'd5
  } tluh_a_op;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1,
    HINT_ACK        = 3'd2
  } tluh_d_op;

  typedef struct packed {
    logic        a_valid;
    tluh_a_op    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_ready;
  } tluh_m2s;

  typedef struct packed {
    logic        d_valid;
    tluh_d_op    d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_denied;
    logic        d_corrupt;
    logic        a_ready;
  } tluh_s2m;
endpackage

module tilelink_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic          tilelink_clock_i,
  input  logic          tilelink_reset_i,
  input  tluh::tluh_m2s tluh_i,
  output tluh::tluh_s2m tluh_o
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [32:0] SPAN  = {1'b0, 32'(DEPTH)} << 2;

  typedef enum logic [1:0] {IDLE, RD, AMO, RESP} state_e;

  state_e         state_q, state_d;
  logic           rdy_en_q, rdy_en_d;
  logic           a_ready_q, a_ready_d;
  logic           d_valid_q, d_valid_d;
  tluh::tluh_d_op d_opcode_q, d_opcode_d;
  logic [1:0]     d_size_q, d_size_d;
  logic [7:0]     d_source_q, d_source_d;
  logic [31:0]    d_data_q, d_data_d;
  logic           d_denied_q, d_denied_d;
  logic           d_corrupt_q, d_corrupt_d;
  tluh::tluh_a_op op_q, op_d;
  logic [2:0]     param_q, param_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]    wdata_q, wdata_d;

  logic [31:0]      mem [DEPTH];
  logic [31:0]      mem_rdata_q;
  logic             mem_we, mem_re;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic [IDX_W-1:0] mem_widx;

  logic [31:0]      off;
  logic [IDX_W-1:0] a_idx;
  logic             accept, in_range, aligned, is_put, is_atomic, legal_op, req_err, denied;
  logic [3:0]       lane;
  logic [31:0]      amo_new;

  assign off    = tluh_i.a_address - BASE_ADDR;
  assign a_idx  = off[IDX_W+1:2];
  assign accept = (state_q == IDLE) && a_ready_q && tluh_i.a_valid;

  // Classify and validate the request currently presented on the A channel.
  always_comb begin
    in_range  = (tluh_i.a_address >= BASE_ADDR) && ({1'b0, off} < SPAN);
    is_put    = (tluh_i.a_opcode == tluh::PUT_FULL_DATA) || (tluh_i.a_opcode == tluh::PUT_PARTIAL_DATA);
    is_atomic = (tluh_i.a_opcode == tluh::ARITHMETIC_DATA) || (tluh_i.a_opcode == tluh::LOGICAL_DATA);
    legal_op  = is_put || is_atomic || (tluh_i.a_opcode == tluh::GET) || (tluh_i.a_opcode == tluh::INTENT);
    case (tluh_i.a_size)
      2'd0:    begin aligned = 1'b1;                            lane = 4'b0001 << tluh_i.a_address[1:0]; end
      2'd1:    begin aligned = ~tluh_i.a_address[0];            lane = tluh_i.a_address[1] ? 4'b1100 : 4'b0011; end
      2'd2:    begin aligned = (tluh_i.a_address[1:0] == 2'd0); lane = 4'hF; end
      default: begin aligned = 1'b0;                            lane = 4'h0; end
    endcase
    req_err = !in_range || !aligned || ((tluh_i.a_mask & ~lane) != 4'h0) || !legal_op
           || (is_atomic && tluh_i.a_size != 2'd2)
           || ((tluh_i.a_opcode == tluh::ARITHMETIC_DATA) && tluh_i.a_param > 3'd4)
           || ((tluh_i.a_opcode == tluh::LOGICAL_DATA) && tluh_i.a_param > 3'd3);
    denied  = req_err || (is_put && tluh_i.a_corrupt);
  end

  // Read-modify-write result from the old word and the latched operand.
  always_comb begin
    amo_new = mem_rdata_q;
    if (op_q == tluh::ARITHMETIC_DATA) begin
      case (param_q)
        3'd0:    amo_new = ($signed(mem_rdata_q) < $signed(wdata_q)) ? mem_rdata_q : wdata_q;
        3'd1:    amo_new = ($signed(mem_rdata_q) > $signed(wdata_q)) ? mem_rdata_q : wdata_q;
        3'd2:    amo_new = (mem_rdata_q < wdata_q) ? mem_rdata_q : wdata_q;
        3'd3:    amo_new = (mem_rdata_q > wdata_q) ? mem_rdata_q : wdata_q;
        default: amo_new = mem_rdata_q + wdata_q;
      endcase
    end else begin
      case (param_q)
        3'd0:    amo_new = mem_rdata_q ^ wdata_q;
        3'd1:    amo_new = mem_rdata_q | wdata_q;
        3'd2:    amo_new = mem_rdata_q & wdata_q;
        default: amo_new = wdata_q;
      endcase
    end
  end

  // Next-state, D-field and memory-port decode for the request FSM.
  always_comb begin
    state_d     = state_q;
    d_valid_d   = d_valid_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_data_d    = d_data_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    op_d        = op_q;
    param_d     = param_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_be      = 4'h0;
    mem_wdata   = 32'h0;
    mem_widx    = idx_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d        = tluh_i.a_opcode;
        param_d     = tluh_i.a_param;
        idx_d       = a_idx;
        wdata_d     = tluh_i.a_data;
        d_size_d    = tluh_i.a_size;
        d_source_d  = tluh_i.a_source;
        d_data_d    = 32'h0;
        d_denied_d  = denied;
        d_opcode_d  = tluh::ACCESS_ACK;
        if (!is_put && legal_op)
          d_opcode_d = (tluh_i.a_opcode == tluh::INTENT) ? tluh::HINT_ACK : tluh::ACCESS_ACK_DATA;
        d_corrupt_d = denied && (d_opcode_d == tluh::ACCESS_ACK_DATA);
        if (denied || is_put || tluh_i.a_opcode == tluh::INTENT) begin
          // Denied, legal Put and Intent all answer on the next edge.
          mem_we    = !denied && is_put;
          mem_be    = tluh_i.a_mask;
          mem_wdata = tluh_i.a_data;
          mem_widx  = a_idx;
          state_d   = RESP;
          d_valid_d = 1'b1;
        end else begin
          mem_re  = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        if (op_q == tluh::GET) begin
          d_data_d  = mem_rdata_q;
          d_valid_d = 1'b1;
          state_d   = RESP;
        end else begin
          state_d = AMO;
        end
      end
      AMO: begin
        mem_we    = 1'b1;
        mem_be    = 4'hF;
        mem_wdata = amo_new;
        d_data_d  = mem_rdata_q;
        d_valid_d = 1'b1;
        state_d   = RESP;
      end
      default: if (tluh_i.d_ready) begin
        d_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    // a_ready is withheld for the first edge after reset release.
    rdy_en_d  = 1'b1;
    a_ready_d = rdy_en_q && (state_d == IDLE);
  end

  // FSM state and all registered outputs; reset aborts any request in flight.
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
    if (!tilelink_reset_i) begin
      state_q     <= IDLE;
      rdy_en_q    <= 1'b0;
      a_ready_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= tluh::ACCESS_ACK;
      d_size_q    <= 2'd0;
      d_source_q  <= 8'd0;
      d_data_q    <= 32'h0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      op_q        <= tluh::PUT_FULL_DATA;
      param_q     <= 3'd0;
      idx_q       <= '0;
      wdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= rdy_en_d;
      a_ready_q   <= a_ready_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_data_q    <= d_data_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      op_q        <= op_d;
      param_q     <= param_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
    end
  end

  // Word memory with byte-enable writes and a registered read port; contents survive reset.
  always_ff @(posedge tilelink_clock_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_re) mem_rdata_q <= mem[a_idx];
  end

  // Pack registered D-channel fields and a_ready onto the response bus.
  always_comb begin
    tluh_o           = '0;
    tluh_o.d_valid   = d_valid_q;
    tluh_o.d_opcode  = d_opcode_q;
    tluh_o.d_param   = 2'd0;
    tluh_o.d_size    = d_size_q;
    tluh_o.d_source  = d_source_q;
    tluh_o.d_sink    = 1'b0;
    tluh_o.d_data    = d_data_q;
    tluh_o.d_denied  = d_denied_q;
    tluh_o.d_corrupt = d_corrupt_q;
    tluh_o.a_ready   = a_ready_q;
  end
endmodule

// File: tb/tb_tilelink_sram_slave.sv
// Directed bench for tilelink_sram_slave: table of requests with expected D responses,
// plus hand sequences for reset release, D-channel back-pressure and reset mid-request.
module tb_tilelink_sram_slave;
  import tluh::*;

  localparam logic [31:0] B = 32'h0000_1000;
  localparam int DEPTH = 16;
  localparam logic [2:0] PF = 3'd0, PP = 3'd1, AR = 3'd2, LG = 3'd3, GT = 3'd4, IN = 3'd5;
  localparam logic [2:0] AK = 3'd0, AD = 3'd1, HA = 3'd2;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tluh_m2s m2s;
  tluh_s2m s2m;
  int      n_chk = 0;
  int      n_pass = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [31:0] e_data;
    int          e_lat;
  } vec_t;

  vec_t vq[$];

  tilelink_sram_slave #(.BASE_ADDR(B), .DEPTH(DEPTH)) dut (
    .tilelink_clock_i(clk),
    .tilelink_reset_i(rst_n),
    .tluh_i(m2s),
    .tluh_o(s2m)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                              input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                              input logic corrupt, input logic [2:0] e_op, input logic e_den,
                              input logic e_cor, input logic [31:0] e_data, input int e_lat);
    vec_t v;
    v.op = op; v.param = param; v.size = size; v.addr = addr; v.mask = mask; v.data = data;
    v.corrupt = corrupt; v.e_op = e_op; v.e_den = e_den; v.e_cor = e_cor; v.e_data = e_data;
    v.e_lat = e_lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the A handshake edge.
  task automatic send_a(input vec_t v, input logic [7:0] src, output bit ok);
    int t = 0;
    m2s.a_valid   = 1'b1;
    m2s.a_opcode  = tluh_a_op'(v.op);
    m2s.a_param   = v.param;
    m2s.a_size    = v.size;
    m2s.a_source  = src;
    m2s.a_address = v.addr;
    m2s.a_mask    = v.mask;
    m2s.a_data    = v.data;
    m2s.a_corrupt = v.corrupt;
    while (s2m.a_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = (s2m.a_ready === 1'b1);
    @(posedge clk);
    @(negedge clk);
    m2s.a_valid = 1'b0;
  endtask

  // Counts handshake-to-d_valid edges, giving up after 8.
  task automatic wait_d(output int lat);
    lat = 1;
    while (s2m.d_valid !== 1'b1 && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    bit ok;
    int lat;
    logic [7:0] src;
    src = 8'(i + 3);
    send_a(v, src, ok);
    check($sformatf("v%0d_accept", i), 32'(ok), 32'd1);
    wait_d(lat);
    check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.e_lat));
    check($sformatf("v%0d_opcode", i), 32'(s2m.d_opcode), 32'(v.e_op));
    check($sformatf("v%0d_denied", i), 32'(s2m.d_denied), 32'(v.e_den));
    check($sformatf("v%0d_corrupt", i), 32'(s2m.d_corrupt), 32'(v.e_cor));
    check($sformatf("v%0d_data", i), s2m.d_data, v.e_data);
    check($sformatf("v%0d_source", i), 32'(s2m.d_source), 32'(src));
    check($sformatf("v%0d_size", i), 32'(s2m.d_size), 32'(v.size));
    check($sformatf("v%0d_param_sink", i), {29'd0, s2m.d_param, s2m.d_sink}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_dvalid_drop", i), 32'(s2m.d_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    int lat;
    vec_t g;
    m2s = '0;

    //          op  prm sz  addr      mask  data           cor  eop den cor e_data         lat
    vq.push_back(mk(PF, 0, 2, B+8,     4'hF, 32'hDEADBEEF, 0,   AK, 0, 0, 32'h0,         1));
    vq.push_back(mk(GT, 0, 2, B+8,     4'hF, 32'h0,        0,   AD, 0, 0, 32'hDEADBEEF,  2));
    vq.push_back(mk(PP, 0, 0, B+32'hA, 4'h4, 32'h00AA0000, 0,   AK, 0, 0, 32'h0,         1));
    vq.push_back(mk(GT, 0, 2, B+8,     4'hF, 32'h0,        0,   AD, 0, 0, 32'hDEAABEEF,  2));
    vq.push_back(mk(AR, 4, 2, B+8,     4'hF, 32'h1,        0,   AD, 0, 0, 32'hDEAABEEF,  3));
    vq.push_back(mk(GT, 0, 2, B+8,     4'hF, 32'h0,        0,   AD, 0, 0, 32'hDEAABEF0,  2));
    vq.push_back(mk(LG, 3, 2, B+8,     4'hF, 32'h0,        0,   AD, 0, 0, 32'hDEAABEF0,  3));
    vq.push_back(mk(GT, 0, 2, B+8,     4'hF, 32'h0,        0,   AD, 0, 0, 32'h0,         2));
    vq.push_back(mk(GT, 0, 2, B+32'h40,4'hF, 32'h0,        0,   AD, 1, 1, 32'h0,         1));
    vq.push_back(mk(PF, 0, 2, B,       4'hF, 32'h11223344, 0,   AK, 0, 0, 32'h0,         1));
    vq.push_back(mk(PF, 0, 2, B+2,     4'hF, 32'h12345678, 0,   AK, 1, 0, 32'h0,         1));
    vq.push_back(mk(GT, 0, 2, B,       4'hF, 32'h0,        0,   AD, 0, 0, 32'h11223344,  2));
    vq.push_back(mk(AR, 5, 2, B,       4'hF, 32'h1,        0,   AD, 1, 1, 32'h0,         1));
    vq.push_back(mk(AR, 0, 2, B,       4'hF, 32'h80000000, 0,   AD, 0, 0, 32'h11223344,  3));
    vq.push_back(mk(AR, 2, 2, B,       4'hF, 32'h5,        0,   AD, 0, 0, 32'h80000000,  3));
    vq.push_back(mk(LG, 0, 2, B,       4'hF, 32'h0F,       0,   AD, 0, 0, 32'h5,         3));
    vq.push_back(mk(LG, 1, 2, B,       4'hF, 32'h30,       0,   AD, 0, 0, 32'hA,         3));
    vq.push_back(mk(LG, 2, 2, B,       4'hF, 32'h0F,       0,   AD, 0, 0, 32'h3A,        3));
    vq.push_back(mk(AR, 1, 2, B,       4'hF, 32'hFFFFFFFF, 0,   AD, 0, 0, 32'hA,         3));
    vq.push_back(mk(AR, 3, 2, B,       4'hF, 32'hFFFFFFFF, 0,   AD, 0, 0, 32'hA,         3));
    vq.push_back(mk(GT, 0, 2, B,       4'hF, 32'h0,        0,   AD, 0, 0, 32'hFFFFFFFF,  2));
    vq.push_back(mk(PF, 0, 2, B,       4'hF, 32'h0,        1,   AK, 1, 0, 32'h0,         1));
    vq.push_back(mk(GT, 0, 2, B,       4'hF, 32'h0,        0,   AD, 0, 0, 32'hFFFFFFFF,  2));
    vq.push_back(mk(IN, 0, 2, B+4,     4'hF, 32'h0,        0,   HA, 0, 0, 32'h0,         1));
    vq.push_back(mk(LG, 0, 1, B,       4'h3, 32'h1,        0,   AD, 1, 1, 32'h0,         1));
    vq.push_back(mk(3'd6,0, 2, B,      4'hF, 32'h0,        0,   AK, 1, 0, 32'h0,         1));
    vq.push_back(mk(GT, 0, 1, B+4,     4'h4, 32'h0,        0,   AD, 1, 1, 32'h0,         1));
    vq.push_back(mk(PF, 0, 2, B+4,     4'hF, 32'hA5A5A5A5, 0,   AK, 0, 0, 32'h0,         1));
    vq.push_back(mk(PP, 0, 1, B+6,     4'hC, 32'hBEEF0000, 0,   AK, 0, 0, 32'h0,         1));
    vq.push_back(mk(GT, 0, 2, B+4,     4'hF, 32'h0,        0,   AD, 0, 0, 32'hBEEFA5A5,  2));
    vq.push_back(mk(GT, 0, 2, B-4,     4'hF, 32'h0,        0,   AD, 1, 1, 32'h0,         1));
    vq.push_back(mk(PF, 0, 2, B+32'h3C,4'hF, 32'h0BADF00D, 0,   AK, 0, 0, 32'h0,         1));
    vq.push_back(mk(GT, 0, 2, B+32'h3C,4'hF, 32'h0,        0,   AD, 0, 0, 32'h0BADF00D,  2));

    // Reset state and a_ready release timing.
    repeat (2) @(negedge clk);
    check("rst_a_ready", 32'(s2m.a_ready), 32'd0);
    check("rst_d_valid", 32'(s2m.d_valid), 32'd0);
    check("rst_d_fields", s2m.d_data | 32'(s2m.d_opcode) | 32'(s2m.d_source) | 32'(s2m.d_size), 32'd0);
    check("rst_d_flags", {29'd0, s2m.d_denied, s2m.d_corrupt, s2m.d_sink}, 32'd0);
    rst_n = 1'b1;
    m2s.d_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rel_edge1_a_ready", 32'(s2m.a_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    check("rel_edge2_a_ready", 32'(s2m.a_ready), 32'd1);

    foreach (vq[i]) run_vec(i, vq[i]);

    // D back-pressure on a Get: hold d_ready low for 5 cycles.
    m2s.d_ready = 1'b0;
    g = mk(GT, 0, 2, B, 4'hF, 32'h0, 0, AD, 0, 0, 32'hFFFFFFFF, 2);
    send_a(g, 8'h55, ok);
    check("bp_accept", 32'(ok), 32'd1);
    wait_d(lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("bp%0d_d_valid", k), 32'(s2m.d_valid), 32'd1);
      check($sformatf("bp%0d_data", k), s2m.d_data, 32'hFFFFFFFF);
      check($sformatf("bp%0d_opcode_src", k), {21'd0, s2m.d_opcode, s2m.d_source}, {21'd0, AD, 8'h55});
      check($sformatf("bp%0d_a_ready", k), 32'(s2m.a_ready), 32'd0);
    end
    m2s.d_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_done_d_valid", 32'(s2m.d_valid), 32'd0);
    check("bp_done_a_ready", 32'(s2m.a_ready), 32'd1);

    // Reset while a Put response is pending: the committed write must survive.
    m2s.d_ready = 1'b0;
    g = mk(PF, 0, 2, B+32'h3C, 4'hF, 32'hCAFEF00D, 0, AK, 0, 0, 32'h0, 1);
    send_a(g, 8'h21, ok);
    check("rp_d_valid_pending", 32'(s2m.d_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rp_d_valid_rst", 32'(s2m.d_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m2s.d_ready = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    g = mk(GT, 0, 2, B+32'h3C, 4'hF, 32'h0, 0, AD, 0, 0, 32'hCAFEF00D, 2);
    run_vec(100, g);

    // Reset while a Get is in RD: no response, a_ready returns on the second edge.
    g = mk(GT, 0, 2, B+8, 4'hF, 32'h0, 0, AD, 0, 0, 32'h0, 2);
    send_a(g, 8'h77, ok);
    check("rr_accept", 32'(ok), 32'd1);
    check("rr_in_rd_d_valid", 32'(s2m.d_valid), 32'd0);
    #1 rst_n = 1'b0;
    #1 check("rr_rst_d_valid", 32'(s2m.d_valid), 32'd0);
    check("rr_rst_a_ready", 32'(s2m.a_ready), 32'd0);
    check("rr_rst_d_source", 32'(s2m.d_source), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rr_edge1_a_ready", 32'(s2m.a_ready), 32'd0);
    check("rr_edge1_d_valid", 32'(s2m.d_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check("rr_edge2_a_ready", 32'(s2m.a_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("rr_stale%0d_d_valid", k), 32'(s2m.d_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
